// File: rtl/btpipe_pkg.sv
// Shared types and constants for the block-throttled pipe-out scheduler.
// Optional per-block header is selected with BTPIPE_HEADER_EN.
package btpipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_READY,
    ST_XFER
  } state_e;

  localparam logic [15:0] HDR_MAGIC       = 16'hA5A5;
  localparam int          DEF_NUM_CH      = 4;
  localparam int          DEF_BLOCK_WORDS = 256;
  localparam int          DEF_LEVEL_W     = 10;

  typedef struct packed {
    logic [15:0] magic;
    logic [7:0]  ch;
    logic [7:0]  seq;
  } blk_hdr_t;

  function automatic blk_hdr_t mk_hdr(input logic [7:0] ch, input logic [7:0] seq);
    blk_hdr_t h;
    h.magic = HDR_MAGIC;
    h.ch    = ch;
    h.seq   = seq;
    return h;
  endfunction

endpackage

// File: rtl/btpipe_block_scheduler_rr_arbiter.sv
// Round-robin search over channel eligibility, starting just after last_grant.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant_oh,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              valid
);

  int k;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    k         = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      k = (int'(last_grant) + i) % NUM_CH;
      if (!valid && elig[k]) begin
        valid       = 1'b1;
        grant_idx   = IDX_W'(k);
        grant_oh[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btpipe_block_scheduler.sv
// Multiplexes NUM_CH FWFT capture FIFOs onto one block-throttled pipe-out.
// Define BTPIPE_HEADER_EN to prefix each block with a {magic, ch, seq} word.
module btpipe_block_scheduler
  import btpipe_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int LEVEL_W     = DEF_LEVEL_W
) (
  input  logic                      ti_clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_CH*LEVEL_W-1:0] ch_level,
  input  logic [NUM_CH*32-1:0]      ch_data,
  output logic [NUM_CH-1:0]         ch_rd_en,
  input  logic                      ep_read,
  input  logic                      ep_blockstrobe,
  output logic                      ep_ready,
  output logic [31:0]               ep_datain,
  output logic [31:0]               blocks_sent
);

`ifdef BTPIPE_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int PAYLOAD = BLOCK_WORDS - HDR_WORDS;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0]   LAST_W    = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [LEVEL_W:0]   PAYLOAD_L = (LEVEL_W+1)'(PAYLOAD);
  localparam logic [IDX_W-1:0]   LAST_CH   = IDX_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][LEVEL_W-1:0] lvl;
  logic [NUM_CH-1:0][31:0]        dat;
  logic [NUM_CH-1:0]              elig;

  assign lvl = ch_level;
  assign dat = ch_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_elig
    assign elig[c] = ({1'b0, lvl[c]} >= PAYLOAD_L);
  end

  state_e             state, state_nx;
  logic [IDX_W-1:0]   grant, last_grant;
  logic [NUM_CH-1:0]  grant_oh;
  logic [CNT_W-1:0]   word_cnt;
  logic               ep_ready_q;
  logic [31:0]        blocks_q;

  logic [NUM_CH-1:0]  arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .elig       (elig),
    .last_grant (last_grant),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx),
    .valid      (arb_vld)
  );

  logic in_xfer, rd_last, is_pay, pop;
  logic [31:0] cur_word;

  assign in_xfer = (state == ST_XFER);
  assign rd_last = in_xfer && ep_read && (word_cnt == LAST_W);

`ifdef BTPIPE_HEADER_EN
  logic [NUM_CH-1:0][7:0] seq;
  blk_hdr_t               hdr;

  assign hdr    = mk_hdr(8'(grant), seq[grant]);
  assign is_pay = (word_cnt != '0);

  always_ff @(posedge ti_clk or negedge reset_n) begin
    if (!reset_n)     seq        <= '0;
    else if (rd_last) seq[grant] <= seq[grant] + 8'd1;
  end

  always_comb begin
    cur_word = dat[grant];
    if (!is_pay) cur_word = hdr;
  end
`else
  assign is_pay   = 1'b1;
  assign cur_word = dat[grant];
`endif

  assign pop       = in_xfer && ep_read && is_pay;
  assign ch_rd_en  = pop ? grant_oh : '0;
  assign ep_datain = in_xfer ? cur_word : 32'd0;
  assign ep_ready  = ep_ready_q;
  assign blocks_sent = blocks_q;

  always_ff @(posedge ti_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (enable) state_nx = ST_ARB;
      ST_ARB: begin
        if (!enable)     state_nx = ST_IDLE;
        else if (arb_vld) state_nx = ST_READY;
      end
      // Once committed to the host, a block is held regardless of enable.
      ST_READY: if (ep_blockstrobe) state_nx = ST_XFER;
      ST_XFER:  if (rd_last) state_nx = ST_ARB;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ti_clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= '0;
      grant_oh   <= '0;
      last_grant <= LAST_CH;
      word_cnt   <= '0;
      ep_ready_q <= 1'b0;
      blocks_q   <= '0;
    end else begin
      ep_ready_q <= (state == ST_READY) && !ep_blockstrobe;
      if (state == ST_ARB && enable && arb_vld) begin
        grant    <= arb_idx;
        grant_oh <= arb_oh;
      end
      if (state == ST_READY && ep_blockstrobe) word_cnt <= '0;
      if (in_xfer && ep_read) begin
        if (rd_last) begin
          word_cnt   <= '0;
          last_grant <= grant;
          blocks_q   <= blocks_q + 32'd1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule
